// File: rtl/gpio_sched_pkg.sv
// Shared constants for the gpio interrupt sequencer: FSM encodings, op indices and
// the target gpio register map (word indices, matching gpio_define.sv).
package gpio_sched_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETUP   = 2'd1;
  localparam logic [1:0] ST_ACCESS  = 2'd2;
  localparam logic [1:0] ST_RD_WAIT = 2'd3;

  localparam logic [1:0] OP_INTEN     = 2'd0;
  localparam logic [1:0] OP_INTTYPE0  = 2'd1;
  localparam logic [1:0] OP_INTTYPE1  = 2'd2;
  localparam logic [1:0] OP_INTSTATUS = 2'd3;

  localparam logic [4:0] GPIO_INTEN     = 5'd3;
  localparam logic [4:0] GPIO_INTTYPE0  = 5'd4;
  localparam logic [4:0] GPIO_INTTYPE1  = 5'd5;
  localparam logic [4:0] GPIO_INTSTATUS = 5'd6;

  function automatic logic [4:0] op_reg_idx(input logic [1:0] op);
    logic [4:0] r;
    case (op)
      OP_INTEN:    r = GPIO_INTEN;
      OP_INTTYPE0: r = GPIO_INTTYPE0;
      OP_INTTYPE1: r = GPIO_INTTYPE1;
      default:     r = GPIO_INTSTATUS;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] op_addr(input logic [31:0] base, input logic [1:0] op);
    return base + {25'd0, op_reg_idx(op), 2'b00};
  endfunction

endpackage

// File: rtl/gpio_irq_sched_rr_arb.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping from N-1 to 0. Returns one-hot grant, its index and an any-request flag.
module rr_arb #(
  parameter int N = 32
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int W = $clog2(N);

  logic [N-1:0] hi_req;
  logic [N-1:0] pick;

  always_comb begin
    hi_req = '0;
    for (int k = 0; k < N; k++) hi_req[k] = req[k] && (k >= int'(ptr));
    // Nothing at/after ptr means the search wraps to the lowest request.
    pick = (|hi_req) ? hi_req : req;
    idx  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (pick[k]) idx = W'(k);
    end
    any   = |req;
    grant = any ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
  end

endmodule

// File: rtl/gpio_irq_sched.sv
// APB4 master sequencer for one apb4_gpio: writes interrupt config, reads INTSTATUS on irq,
// and dispatches pending pins round-robin over a valid/ready event port.
//
// state      | meaning
// IDLE       | bus idle; accepts cfg_start_i (priority) or irq_i
// SETUP      | APB setup phase, psel=1 penable=0
// ACCESS     | APB access phase, held until pready_i
// RD_WAIT    | one cycle after INTSTATUS read while gpio irq drops
module gpio_irq_sched
  import gpio_sched_pkg::*;
#(
  parameter int          GPIO_NUM  = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                        pclk_i,
  input  logic                        prst_i,
  input  logic                        cfg_start_i,
  input  logic [GPIO_NUM-1:0]         cfg_inten_i,
  input  logic [GPIO_NUM-1:0]         cfg_type0_i,
  input  logic [GPIO_NUM-1:0]         cfg_type1_i,
  input  logic                        irq_i,
  output logic [31:0]                 paddr_o,
  output logic                        psel_o,
  output logic                        penable_o,
  output logic                        pwrite_o,
  output logic [31:0]                 pwdata_o,
  input  logic [31:0]                 prdata_i,
  input  logic                        pready_i,
  input  logic                        pslverr_i,
  output logic                        evt_valid_o,
  output logic [$clog2(GPIO_NUM)-1:0] evt_pin_o,
  input  logic                        evt_ready_i,
  output logic                        busy_o,
  output logic                        err_o
);
  localparam int PW = $clog2(GPIO_NUM);

  logic [1:0]          state;
  logic [1:0]          idx;
  logic [1:0]          wr_idx;
  logic [31:0]         paddr_q;
  logic                err_q;
  logic [GPIO_NUM-1:0] inten_q, type0_q, type1_q;
  logic [GPIO_NUM-1:0] wr_val;

  logic [GPIO_NUM-1:0] pending;
  logic [GPIO_NUM-1:0] grant;
  logic [GPIO_NUM-1:0] grant_clr;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       arb_idx;
  logic                arb_any;
  logic [PW-1:0]       evt_pin_q;
  logic                evt_valid_q;

  logic bus_act, rd_done, adv;

  assign bus_act = (state == ST_SETUP) || (state == ST_ACCESS);
  assign rd_done = (state == ST_ACCESS) && pready_i && !pslverr_i && (idx == OP_INTSTATUS);
  assign adv     = !evt_valid_q || evt_ready_i;

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state   <= ST_IDLE;
      idx     <= OP_INTEN;
      wr_idx  <= OP_INTEN;
      paddr_q <= '0;
      err_q   <= 1'b0;
      inten_q <= '0;
      type0_q <= '0;
      type1_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_start_i) begin
            inten_q <= cfg_inten_i;
            type0_q <= cfg_type0_i;
            type1_q <= cfg_type1_i;
            err_q   <= 1'b0;
            idx     <= OP_INTEN;
            wr_idx  <= OP_INTEN;
            paddr_q <= op_addr(BASE_ADDR, OP_INTEN);
            state   <= ST_SETUP;
          end else if (irq_i) begin
            idx     <= OP_INTSTATUS;
            paddr_q <= op_addr(BASE_ADDR, OP_INTSTATUS);
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: state <= ST_ACCESS;
        ST_ACCESS: begin
          if (pready_i) begin
            if (pslverr_i) begin
              err_q <= 1'b1;
              state <= ST_IDLE;
            end else if (idx == OP_INTSTATUS) begin
              state <= ST_RD_WAIT;
            end else if (idx == OP_INTTYPE1) begin
              state <= ST_IDLE;
            end else begin
              idx     <= idx + 2'd1;
              wr_idx  <= idx + 2'd1;
              paddr_q <= op_addr(BASE_ADDR, idx + 2'd1);
              state   <= ST_SETUP;
            end
          end
        end
        ST_RD_WAIT: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // pwdata follows the last write op, so it holds through reads and idle.
  always_comb begin
    case (wr_idx)
      OP_INTEN:    wr_val = inten_q;
      OP_INTTYPE0: wr_val = type0_q;
      default:     wr_val = type1_q;
    endcase
  end

  rr_arb #(.N(GPIO_NUM)) u_arb (
    .req   (pending),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign grant_clr = adv ? grant : '0;

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      pending     <= '0;
      rr_ptr      <= '0;
      evt_valid_q <= 1'b0;
      evt_pin_q   <= '0;
    end else begin
      if (adv) begin
        evt_valid_q <= arb_any;
        if (arb_any) begin
          evt_pin_q <= arb_idx;
          rr_ptr    <= (arb_idx == PW'(GPIO_NUM - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      // OR-in after the clear: a freshly re-reported pin stays pending.
      pending <= (pending & ~grant_clr) | (rd_done ? prdata_i[GPIO_NUM-1:0] : '0);
    end
  end

  assign paddr_o     = paddr_q;
  assign pwdata_o    = 32'(wr_val);
  assign psel_o      = bus_act;
  assign penable_o   = (state == ST_ACCESS);
  assign pwrite_o    = bus_act && (idx != OP_INTSTATUS);
  assign busy_o      = (state != ST_IDLE);
  assign err_o       = err_q;
  assign evt_valid_o = evt_valid_q;
  assign evt_pin_o   = evt_pin_q;

endmodule

// File: tb/tb_gpio_irq_sched.sv
// Scoreboard bench for gpio_irq_sched: directed stimulus pushes expected APB transfers and
// pin events; a monitor pops and compares them as the DUT presents them.
module tb_gpio_irq_sched;
  localparam int          N      = 32;
  localparam logic [31:0] BASE   = 32'h4000_1000;
  localparam logic [31:0] A_INTEN = 32'h4000_100C;
  localparam logic [31:0] A_TYPE0 = 32'h4000_1010;
  localparam logic [31:0] A_TYPE1 = 32'h4000_1014;
  localparam logic [31:0] A_STAT  = 32'h4000_1018;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [N-1:0] cfg_inten = '0, cfg_type0 = '0, cfg_type1 = '0;
  logic        irq = 1'b0;
  logic [31:0] paddr, pwdata;
  logic        psel, penable, pwrite;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;
  logic        evt_valid;
  logic [4:0]  evt_pin;
  logic        evt_ready = 1'b1;
  logic        busy, err;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } apb_exp_t;

  apb_exp_t    exp_apb[$];
  int          exp_evt[$];
  int          checks = 0;
  int          failures = 0;
  int          wait_states = 0;
  int          err_at = -1;
  int          xfer_cnt = 0;
  int          acc_cnt = 0;
  int          acc_len = 0;
  logic [31:0] rd_data = '0;

  gpio_irq_sched #(.GPIO_NUM(N), .BASE_ADDR(BASE)) dut (
    .pclk_i      (clk),
    .prst_i      (rst),
    .cfg_start_i (cfg_start),
    .cfg_inten_i (cfg_inten),
    .cfg_type0_i (cfg_type0),
    .cfg_type1_i (cfg_type1),
    .irq_i       (irq),
    .paddr_o     (paddr),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .pwdata_o    (pwdata),
    .prdata_i    (prdata),
    .pready_i    (pready),
    .pslverr_i   (pslverr),
    .evt_valid_o (evt_valid),
    .evt_pin_o   (evt_pin),
    .evt_ready_i (evt_ready),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    apb_exp_t e;
    e.wr = 1'b1; e.addr = a; e.data = d;
    exp_apb.push_back(e);
  endtask

  task automatic push_rd(input logic [31:0] a);
    apb_exp_t e;
    e.wr = 1'b0; e.addr = a; e.data = '0;
    exp_apb.push_back(e);
  endtask

  // APB slave: wait_states extra ACCESS cycles, pslverr on transfer number err_at.
  task automatic slave();
    forever begin
      @(posedge clk);
      #1;
      if (rst || !(psel && penable)) begin
        pready = 1'b0; pslverr = 1'b0; acc_cnt = 0;
      end else begin
        pready  = (acc_cnt >= wait_states);
        pslverr = pready && (xfer_cnt == err_at);
        prdata  = rd_data;
        if (pready) xfer_cnt++;
        acc_cnt++;
      end
    end
  endtask

  task automatic monitor();
    apb_exp_t e;
    int       p;
    forever begin
      @(negedge clk);
      if (!rst && psel && penable) begin
        acc_len++;
        if (pready) begin
          if (exp_apb.size() == 0) begin
            checks++; failures++;
            $display("FAIL apb_unexpected actual addr=%0h write=%0b required none", paddr, pwrite);
          end else begin
            e = exp_apb.pop_front();
            chk("apb_write", 32'(pwrite), 32'(e.wr));
            chk("apb_addr", paddr, e.addr);
            if (e.wr) chk("apb_wdata", pwdata, e.data);
            chk("access_len", acc_len, wait_states + 1);
          end
          acc_len = 0;
        end
      end else begin
        acc_len = 0;
      end
      if (!rst && evt_valid && evt_ready) begin
        if (exp_evt.size() == 0) begin
          checks++; failures++;
          $display("FAIL evt_unexpected actual pin=%0d required none", evt_pin);
        end else begin
          p = exp_evt.pop_front();
          chk("evt_pin", 32'(evt_pin), p);
        end
      end
    end
  endtask

  task automatic pulse_cfg(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic with_irq);
    @(posedge clk);
    #1;
    cfg_inten = a; cfg_type0 = b; cfg_type1 = c;
    cfg_start = 1'b1;
    if (with_irq) irq = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  // gpio model: irq stays high through the RD_WAIT cycle, then drops.
  task automatic wait_read_drop();
    bit seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (psel && penable && pready && !pwrite) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL irq_read_timeout actual=no read required=INTSTATUS read");
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    irq = 1'b0;
  endtask

  task automatic do_irq(input logic [31:0] data);
    rd_data = data;
    push_rd(A_STAT);
    @(posedge clk);
    #1;
    irq = 1'b1;
    wait_read_drop();
  endtask

  task automatic wait_quiet(input int max);
    bit ok = 0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (!busy && !irq && !evt_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL quiet_timeout actual busy=%0b valid=%0b required idle", busy, evt_valid);
    end
  endtask

  initial begin
    fork
      slave();
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_pwrite", 32'(pwrite), 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_evt_valid", 32'(evt_valid), 0);
    chk("rst_evt_pin", 32'(evt_pin), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // config write sequence, zero wait states
    push_wr(A_INTEN, 32'h0000_000F);
    push_wr(A_TYPE0, 32'h0000_0003);
    push_wr(A_TYPE1, 32'h0000_000C);
    pulse_cfg(32'hF, 32'h3, 32'hC, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("cfg_psel_continuous", 32'(psel), 1);
    end
    @(negedge clk);
    chk("cfg_busy_cycle7", 32'(busy), 0);
    wait_quiet(20);

    // irq service: one read, pins 0 then 2
    exp_evt.push_back(0);
    exp_evt.push_back(2);
    do_irq(32'h0000_0005);
    wait_quiet(30);

    // round-robin wrap: pin 4 leaves rr_ptr=5, then 31 precedes 0
    exp_evt.push_back(4);
    do_irq(32'h0000_0010);
    wait_quiet(30);
    exp_evt.push_back(31);
    exp_evt.push_back(0);
    do_irq(32'h8000_0001);
    wait_quiet(30);

    // pslverr on second write aborts the third
    err_at = xfer_cnt + 1;
    push_wr(A_INTEN, 32'h0000_00A5);
    push_wr(A_TYPE0, 32'h0000_005A);
    pulse_cfg(32'hA5, 32'h5A, 32'h33, 1'b0);
    wait_quiet(30);
    chk("slverr_err_set", 32'(err), 1);
    err_at = -1;
    push_wr(A_INTEN, 32'h0000_0011);
    push_wr(A_TYPE0, 32'h0000_0022);
    push_wr(A_TYPE1, 32'h0000_0044);
    pulse_cfg(32'h11, 32'h22, 32'h44, 1'b0);
    @(negedge clk);
    chk("cfg_clears_err", 32'(err), 0);
    wait_quiet(30);

    // config and irq together with two wait states: config first, then the read
    wait_states = 2;
    push_wr(A_INTEN, 32'h0000_0001);
    push_wr(A_TYPE0, 32'h0000_0002);
    push_wr(A_TYPE1, 32'h0000_0004);
    push_rd(A_STAT);
    rd_data = 32'h0000_0100;
    exp_evt.push_back(8);
    pulse_cfg(32'h1, 32'h2, 32'h4, 1'b1);
    wait_read_drop();
    wait_quiet(60);
    wait_states = 0;

    // consumer stall: pin 6 held while a second read adds pin 9
    evt_ready = 1'b0;
    exp_evt.push_back(6);
    exp_evt.push_back(9);
    do_irq(32'h0000_0040);
    do_irq(32'h0000_0200);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(evt_valid), 1);
      chk("stall_pin", 32'(evt_pin), 6);
    end
    @(posedge clk);
    #1;
    evt_ready = 1'b1;
    wait_quiet(30);

    // reset in the middle of an ACCESS phase
    wait_states = 5;
    pulse_cfg(32'h77, 32'h66, 32'h55, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_psel", 32'(psel), 0);
    chk("midrst_penable", 32'(penable), 0);
    chk("midrst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_states = 0;
    repeat (5) @(negedge clk);
    chk("midrst_stays_idle", 32'(busy), 0);

    chk("apb_queue_empty", exp_apb.size(), 0);
    chk("evt_queue_empty", exp_evt.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
